// File: rtl/pipeline_hazard_ctrl.sv
// pipeline_hazard_ctrl
// Stall/flush sequencer for the 5-stage pipeline. It produces the hold, flush
// and bubble controls for PC, IF_ID, ID_EX, EX_MEM and MEM_WB. It holds no
// datapath values.
//
// Hazards are resolved in fixed priority order:
//   1. dcache miss stall (full freeze)
//   2. load-use          (1-cycle bubble)
//   3. taken branch      (IF_ID flush)
//
// A watchdog counts dcache wait cycles. On timeout it locks the pipeline in
// ERROR, and only reset leaves that state.
//
// Optional build macro HAZARD_PERF_CNT_EN adds three 32-bit performance
// counters: freeze cycles, bubble cycles and flush cycles.
module pipeline_hazard_ctrl #(
  parameter int MAX_WAIT = 256,  // dcache wait cycles allowed before timeout (2..65535)
  parameter int WAIT_W   = 16    // wait counter width, MAX_WAIT < 2**WAIT_W
) (
  input  logic       clk_i,
  input  logic       rst_i,            // asynchronous, active-low
  input  logic       ID_EX_MemRead_i,
  input  logic [4:0] ID_EX_Rd_i,
  input  logic [4:0] IF_ID_Rs1_i,
  input  logic [4:0] IF_ID_Rs2_i,
  input  logic       Branch_Taken_i,
  input  logic       Mem_Stall_i,
  output logic       PC_Write_o,
  output logic       IF_ID_Stall_o,
  output logic       IF_ID_Flush_o,
  output logic       ID_EX_Bubble_o,
  output logic       Pipe_Freeze_o,
  output logic       Timeout_o,
`ifdef HAZARD_PERF_CNT_EN
  output logic [1:0]  State_o,
  output logic [31:0] Perf_Mem_Stall_o,
  output logic [31:0] Perf_Load_Use_o,
  output logic [31:0] Perf_Flush_o
`else
  output logic [1:0]  State_o
`endif
);

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MEM_WAIT = 2'd1,
    ERROR    = 2'd2
  } state_e;

  // The RUN-state miss cycle counts as wait 1. The cycle that sees LAST_WAIT
  // while still stalled is therefore the MAX_WAIT-th stall cycle.
  localparam logic [WAIT_W-1:0] LAST_WAIT = WAIT_W'(MAX_WAIT - 1);
  localparam logic [WAIT_W-1:0] WAIT_SAT  = {WAIT_W{1'b1}};

  state_e            state_q, state_d;
  logic [WAIT_W-1:0] wait_cnt_q, wait_cnt_d;
  logic              timeout_q, timeout_d;

  logic load_use;
  logic pc_write, if_id_stall, if_id_flush, id_ex_bubble, pipe_freeze;
  logic wait_expired;

  // Load in EX writes a register that the instruction in ID reads (x0 never hazards)
  always_comb begin
    load_use = ID_EX_MemRead_i && (ID_EX_Rd_i != 5'd0) &&
               ((ID_EX_Rd_i == IF_ID_Rs1_i) || (ID_EX_Rd_i == IF_ID_Rs2_i));
  end

  // Watchdog trip: still stalled on the last permitted wait cycle
  always_comb begin
    wait_expired = (state_q == MEM_WAIT) && Mem_Stall_i && (wait_cnt_q == LAST_WAIT);
  end

  // State, wait counter and sticky timeout registers
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q    <= RUN;
      wait_cnt_q <= '0;
      timeout_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
      timeout_q  <= timeout_d;
    end
  end

  // Next-state, wait-count and timeout logic
  always_comb begin
    state_d    = state_q;
    wait_cnt_d = wait_cnt_q;
    timeout_d  = timeout_q;
    case (state_q)
      RUN: begin
        if (Mem_Stall_i) begin
          state_d    = MEM_WAIT;
          wait_cnt_d = WAIT_W'(1);
        end else begin
          wait_cnt_d = '0;
        end
      end
      MEM_WAIT: begin
        if (Mem_Stall_i) begin
          // Saturate rather than wrap, in case the watchdog is bypassed by parameters
          if (wait_cnt_q != WAIT_SAT) begin
            wait_cnt_d = wait_cnt_q + WAIT_W'(1);
          end
          if (wait_expired) begin
            state_d   = ERROR;
            timeout_d = 1'b1;
          end
        end else begin
          state_d    = RUN;
          wait_cnt_d = '0;
        end
      end
      ERROR: begin
        // Locked until reset; inputs are deliberately ignored
        state_d   = ERROR;
        timeout_d = 1'b1;
      end
      default: begin
        state_d    = ERROR;
        timeout_d  = 1'b1;
      end
    endcase
  end

  // Mealy control outputs: zero-latency stalls, everything forced low during reset
  always_comb begin
    pc_write     = 1'b0;
    if_id_stall  = 1'b0;
    if_id_flush  = 1'b0;
    id_ex_bubble = 1'b0;
    pipe_freeze  = 1'b0;
    if (rst_i) begin
      case (state_q)
        RUN, MEM_WAIT: begin
          if (Mem_Stall_i) begin
            // Full freeze. Pending load-use or branch is re-presented after release.
            pipe_freeze = 1'b1;
            if_id_stall = 1'b1;
          end else if (load_use) begin
            // Bubble wins over branch; the branch re-resolves next cycle
            if_id_stall  = 1'b1;
            id_ex_bubble = 1'b1;
          end else if (Branch_Taken_i) begin
            if_id_flush = 1'b1;
            pc_write    = 1'b1;
          end else begin
            pc_write = 1'b1;
          end
        end
        default: begin
          // ERROR (and any illegal encoding) keeps the whole pipe frozen
          pipe_freeze = 1'b1;
          if_id_stall = 1'b1;
        end
      endcase
    end
  end

  assign PC_Write_o     = pc_write;
  assign IF_ID_Stall_o  = if_id_stall;
  assign IF_ID_Flush_o  = if_id_flush;
  assign ID_EX_Bubble_o = id_ex_bubble;
  assign Pipe_Freeze_o  = pipe_freeze;
  assign Timeout_o      = rst_i & timeout_q;
  assign State_o        = state_q;

`ifdef HAZARD_PERF_CNT_EN
  logic [31:0] perf_stall_q, perf_bubble_q, perf_flush_q;

  // Event counters, wrapping modulo 2**32
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      perf_stall_q  <= '0;
      perf_bubble_q <= '0;
      perf_flush_q  <= '0;
    end else begin
      if (pipe_freeze)  perf_stall_q  <= perf_stall_q + 32'd1;
      if (id_ex_bubble) perf_bubble_q <= perf_bubble_q + 32'd1;
      if (if_id_flush)  perf_flush_q  <= perf_flush_q + 32'd1;
    end
  end

  assign Perf_Mem_Stall_o = perf_stall_q;
  assign Perf_Load_Use_o  = perf_bubble_q;
  assign Perf_Flush_o     = perf_flush_q;
`endif

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Self-checking bench for pipeline_hazard_ctrl (MAX_WAIT=8).
// Inputs change 1 time unit after the rising edge. Combinational outputs are
// sampled 3 units later, well away from either clock edge.
`timescale 1ns/1ps
module tb_pipeline_hazard_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       mem_read;
  logic [4:0] rd, rs1, rs2;
  logic       br_taken;
  logic       mem_stall;
  logic       pc_write, ifid_stall, ifid_flush, idex_bubble, freeze, timeout;
  logic [1:0] state;
`ifdef HAZARD_PERF_CNT_EN
  logic [31:0] perf_stall, perf_lu, perf_flush;
`endif

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  pipeline_hazard_ctrl #(.MAX_WAIT(8), .WAIT_W(16)) dut (
    .clk_i           (clk),
    .rst_i           (rst_n),
    .ID_EX_MemRead_i (mem_read),
    .ID_EX_Rd_i      (rd),
    .IF_ID_Rs1_i     (rs1),
    .IF_ID_Rs2_i     (rs2),
    .Branch_Taken_i  (br_taken),
    .Mem_Stall_i     (mem_stall),
    .PC_Write_o      (pc_write),
    .IF_ID_Stall_o   (ifid_stall),
    .IF_ID_Flush_o   (ifid_flush),
    .ID_EX_Bubble_o  (idex_bubble),
    .Pipe_Freeze_o   (freeze),
    .Timeout_o       (timeout),
`ifdef HAZARD_PERF_CNT_EN
    .State_o         (state),
    .Perf_Mem_Stall_o(perf_stall),
    .Perf_Load_Use_o (perf_lu),
    .Perf_Flush_o    (perf_flush)
`else
    .State_o         (state)
`endif
  );

  // Output packing: {pc_write, stall, flush, bubble, freeze, timeout, state[1:0]}
  localparam logic [7:0] ALL_ZERO   = 8'b0000_0000;
  localparam logic [7:0] IDLE_RUN   = 8'b1000_0000;
  localparam logic [7:0] BUB_RUN    = 8'b0101_0000;
  localparam logic [7:0] FLUSH_RUN  = 8'b1010_0000;
  localparam logic [7:0] FRZ_RUN    = 8'b0100_1000;
  localparam logic [7:0] FRZ_WAIT   = 8'b0100_1001;
  localparam logic [7:0] IDLE_WAIT  = 8'b1000_0001;
  localparam logic [7:0] BUB_WAIT   = 8'b0101_0001;
  localparam logic [7:0] ERR_STATE  = 8'b0100_1110;

  typedef struct {
    logic       mr;
    logic [4:0] rd;
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic       br;
    logic [7:0] exp;
  } vec_t;

  vec_t tv [9];

  function automatic logic [7:0] outs();
    return {pc_write, ifid_stall, ifid_flush, idex_bubble, freeze, timeout, state};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end else begin
      $display("ok   %s: %0h", name, act);
    end
  endtask

  task automatic drive(input logic mr, input logic [4:0] d, input logic [4:0] s1,
                       input logic [4:0] s2, input logic br, input logic ms);
    mem_read  = mr;
    rd        = d;
    rs1       = s1;
    rs2       = s2;
    br_taken  = br;
    mem_stall = ms;
  endtask

  // Advance to 1 unit past the next rising edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Global time bound
  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "bench timeout");
  end

  initial begin
    tv[0] = '{1'b0, 5'd0,  5'd0,  5'd0,  1'b0, IDLE_RUN};   // idle
    tv[1] = '{1'b1, 5'd5,  5'd5,  5'd0,  1'b1, BUB_RUN};    // load-use rs1, beats branch
    tv[2] = '{1'b1, 5'd0,  5'd0,  5'd0,  1'b0, IDLE_RUN};   // rd = x0: no hazard
    tv[3] = '{1'b1, 5'd0,  5'd0,  5'd0,  1'b1, FLUSH_RUN};  // rd = x0 with branch
    tv[4] = '{1'b1, 5'd7,  5'd3,  5'd7,  1'b0, BUB_RUN};    // load-use rs2
    tv[5] = '{1'b0, 5'd7,  5'd7,  5'd7,  1'b0, IDLE_RUN};   // match but not a load
    tv[6] = '{1'b1, 5'd9,  5'd8,  5'd10, 1'b1, FLUSH_RUN};  // load, no match, branch
    tv[7] = '{1'b0, 5'd0,  5'd0,  5'd0,  1'b1, FLUSH_RUN};  // plain branch
    tv[8] = '{1'b1, 5'd31, 5'd1,  5'd31, 1'b0, BUB_RUN};    // load-use on x31

    // Reset held with every hazard source active: all outputs must be 0
    rst_n = 1'b0;
    drive(1'b1, 5'd5, 5'd5, 5'd5, 1'b1, 1'b1);
    repeat (2) tick();
    #3 chk("reset_outputs", 32'(outs()), 32'(ALL_ZERO));

    // Release with Mem_Stall high: freeze in RUN, then MEM_WAIT after the edge
    tick();
    rst_n = 1'b1;
    drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1);
    #3 chk("release_freeze_run", 32'(outs()), 32'(FRZ_RUN));
    tick();
    #3 chk("release_state_wait", 32'(outs()), 32'(FRZ_WAIT));
    tick();
    drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0);
    #3 chk("release_unfreeze", 32'(outs()), 32'(IDLE_WAIT));

    // Single-cycle RUN vectors
    for (int i = 0; i < 9; i++) begin
      tick();
      drive(tv[i].mr, tv[i].rd, tv[i].rs1, tv[i].rs2, tv[i].br, 1'b0);
      #3 chk($sformatf("vec%0d", i), 32'(outs()), 32'(tv[i].exp));
    end

    // Branch flush lasts exactly the cycle it is presented
    tick();
    drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0);
    #3 chk("flush_one_cycle", 32'(outs()), 32'(IDLE_RUN));

    // Dcache miss of 7 cycles (one short of timeout) with load-use and branch pending
    for (int c = 1; c <= 7; c++) begin
      tick();
      drive(1'b1, 5'd5, 5'd5, 5'd0, 1'b1, 1'b1);
      #3 chk($sformatf("miss_cyc%0d", c), 32'(outs()), 32'((c == 1) ? FRZ_RUN : FRZ_WAIT));
    end
    tick();
    drive(1'b1, 5'd5, 5'd5, 5'd0, 1'b1, 1'b0);
    #3 chk("miss_release_bubble", 32'(outs()), 32'(BUB_WAIT));
    tick();
    drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0);
    #3 chk("miss_back_to_run", 32'(outs()), 32'(IDLE_RUN));

    // Timeout: 8 stall cycles lock into ERROR
    for (int c = 1; c <= 8; c++) begin
      tick();
      drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1);
      #3 chk($sformatf("to_cyc%0d", c), 32'(outs()), 32'((c == 1) ? FRZ_RUN : FRZ_WAIT));
    end
    tick();
    #3 chk("timeout_error", 32'(outs()), 32'(ERR_STATE));
    tick();
    drive(1'b1, 5'd4, 5'd4, 5'd0, 1'b1, 1'b0);
    #3 chk("error_ignores_inputs", 32'(outs()), 32'(ERR_STATE));
    tick();
    #3 chk("error_sticky", 32'(outs()), 32'(ERR_STATE));

    // Asynchronous reset mid-cycle clears immediately
    #1 rst_n = 1'b0;
    #1 chk("async_reset_clear", 32'(outs()), 32'(ALL_ZERO));
    tick();
    rst_n = 1'b1;
    drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0);
    #3 chk("after_reset_idle", 32'(outs()), 32'(IDLE_RUN));

    // Reset in the middle of a wait returns to RUN
    tick();
    drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1);
    tick();
    #3 chk("midwait_state", 32'(outs()), 32'(FRZ_WAIT));
    #1 rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0);
    #3 chk("midwait_reset_run", 32'(outs()), 32'(IDLE_RUN));

`ifdef HAZARD_PERF_CNT_EN
    // Counters: 3 freeze cycles, 1 bubble, 2 flushes after a fresh reset
    tick();
    rst_n = 1'b0;
    #2 rst_n = 1'b1;
    for (int c = 0; c < 3; c++) begin
      tick();
      drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1);
    end
    tick();
    drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0);
    tick();
    drive(1'b1, 5'd6, 5'd6, 5'd0, 1'b0, 1'b0);
    tick();
    drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b1, 1'b0);
    tick();
    drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b1, 1'b0);
    tick();
    drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0);
    #3;
    chk("perf_stall", perf_stall, 32'd3);
    chk("perf_load_use", perf_lu, 32'd1);
    chk("perf_flush", perf_flush, 32'd2);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
